cv32e40p_fpu_lat_pipe: RTL and testbench

CV32E40P_FPU_LAT_PIPE -- requirements
Module: cv32e40p_fpu_lat_pipe

---
 rtl/cv32e40p_fpu_lat_pipe.sv | 113 +++++++++++
 tb/tb_cv32e40p_fpu_lat_pipe.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_fpu_lat_pipe.sv
// Fixed-latency FPU result pipe: two latency classes share one slot chain.
// Ports: clk, rst_n, flush_i, in_* (valid/ready/class/data/tag),
//   out_* (valid/ready/data/tag), busy_o.
// Macro CV32E40P_FPU_LAT_PIPE_INORDER_EN forces results out in issue order.
module cv32e40p_fpu_lat_pipe #(
  parameter int WIDTH      = 32,
  parameter int TAG_W      = 5,
  parameter int ADDMUL_LAT = 2,
  parameter int OTHERS_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             in_class_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             busy_o
);

  localparam int MAX_LAT =
    (ADDMUL_LAT > OTHERS_LAT) ? ADDMUL_LAT : OTHERS_LAT;
  // At least one slot so the arrays stay legal when both
  // latencies are zero; that slot is then never written.
  localparam int SL = (MAX_LAT > 0) ? MAX_LAT : 1;

  logic [SL:1]      v_q, v_d;
  logic [WIDTH-1:0] d_q [SL:1];
  logic [WIDTH-1:0] d_d [SL:1];
  logic [TAG_W-1:0] t_q [SL:1];
  logic [TAG_W-1:0] t_d [SL:1];

  int   lat;
  logic adv;
  logic blk;
  logic rdy;
  logic byp;
  logic acc;

  // blk: a slot that would collide with (or be
  // overtaken by) a new op of the selected latency.
  always_comb begin
    lat = in_class_i ? OTHERS_LAT : ADDMUL_LAT;
    adv = !v_q[1] || out_ready_i;
    blk = 1'b0;
    for (int j = 1; j <= SL; j++) begin
`ifdef CV32E40P_FPU_LAT_PIPE_INORDER_EN
      if (j > lat) blk = blk | v_q[j];
`else
      if (j == lat + 1) blk = blk | v_q[j];
`endif
    end
    if (lat == 0) rdy = out_ready_i && !v_q[1] && !blk;
    else          rdy = adv && !blk;
    byp = in_valid_i && (lat == 0) && !v_q[1] && !blk;
  end

  assign in_ready_o  = rst_n && !flush_i && rdy;
  assign acc         = in_valid_i && in_ready_o;
  assign out_valid_o = rst_n && !flush_i && (v_q[1] || byp);
  assign out_data_o  = v_q[1] ? d_q[1] : in_data_i;
  assign out_tag_o   = v_q[1] ? t_q[1] : in_tag_i;
  assign busy_o      = |v_q;

  // Payload moves only with a valid op (shift) or on
  // acceptance; otherwise the flops keep their value.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    t_d = t_q;
    if (flush_i) begin
      v_d = '0;
    end else begin
      if (adv) begin
        for (int i = 1; i < SL; i++) begin
          v_d[i] = v_q[i+1];
          if (v_q[i+1]) begin
            d_d[i] = d_q[i+1];
            t_d[i] = t_q[i+1];
          end
        end
        v_d[SL] = 1'b0;
      end
      if (acc && lat >= 1) begin
        for (int j = 1; j <= SL; j++) begin
          if (j == lat) begin
            v_d[j] = 1'b1;
            d_d[j] = in_data_i;
            t_d[j] = in_tag_i;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      d_q <= '{default: '0};
      t_q <= '{default: '0};
    end else begin
      v_q <= v_d;
      d_q <= d_d;
      t_q <= t_d;
    end
  end

endmodule

// File: tb/tb_cv32e40p_fpu_lat_pipe.sv
// Scoreboard bench for cv32e40p_fpu_lat_pipe (default order mode).
// u0: latencies 2/1 under random traffic; u1: latencies 3/0 directed.
module tb_cv32e40p_fpu_lat_pipe;

  logic        clk = 0;
  logic        rst_n;
  logic        fl, iv, ir, ic, ov, ordy, busy;
  logic [31:0] idt, odt;
  logic [4:0]  itg, otg;
  logic        fl1, iv1, ir1, ic1, ov1, ordy1, busy1;
  logic [31:0] idt1, odt1;
  logic [4:0]  itg1, otg1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  t;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  bit   seen = 0;
  bit   stall_at [0:8191];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cv32e40p_fpu_lat_pipe #(
    .WIDTH(32), .TAG_W(5), .ADDMUL_LAT(2), .OTHERS_LAT(1)
  ) u0 (
    .clk(clk), .rst_n(rst_n), .flush_i(fl),
    .in_valid_i(iv), .in_ready_o(ir), .in_class_i(ic),
    .in_data_i(idt), .in_tag_i(itg),
    .out_valid_o(ov), .out_ready_i(ordy),
    .out_data_o(odt), .out_tag_o(otg), .busy_o(busy)
  );

  cv32e40p_fpu_lat_pipe #(
    .WIDTH(32), .TAG_W(5), .ADDMUL_LAT(3), .OTHERS_LAT(0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .flush_i(fl1),
    .in_valid_i(iv1), .in_ready_o(ir1), .in_class_i(ic1),
    .in_data_i(idt1), .in_tag_i(itg1),
    .out_valid_o(ov1), .out_ready_i(ordy1),
    .out_data_o(odt1), .out_tag_o(otg1), .busy_o(busy1)
  );

  function automatic void chk(input string nm,
                              input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  // Monitor: compares every presented result with the oldest
  // outstanding op; first appearance must be at accept + L
  // plus the number of stalled cycles since acceptance.
  always @(negedge clk) begin
    bit exp_busy;
    int st;
    if (!rst_n) begin
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_ov", 64'(ov), 64'(0));
      q.delete();
      seen = 0;
    end else begin
      exp_busy = 0;
      foreach (q[k]) if (q[k].acc < cyc) exp_busy = 1;
      chk("busy", 64'(busy), 64'(exp_busy));
      if (ov) begin
        if (q.size() == 0) begin
          chk("spurious_out", 64'(ov), 64'(0));
        end else begin
          chk("out_tag", 64'(otg), 64'(q[0].t));
          chk("out_data", 64'(odt), 64'(q[0].d));
          if (!seen) begin
            st = 0;
            for (int k = q[0].acc; k < cyc; k++)
              st += int'(stall_at[k]);
            chk("out_cycle", 64'(cyc),
                64'(q[0].acc + q[0].lat + st));
            seen = 1;
          end
          if (ordy) begin
            void'(q.pop_front());
            seen = 0;
          end
        end
      end
      stall_at[cyc] = ov && !ordy;
      if (fl) begin
        q.delete();
        seen = 0;
      end
    end
  end

  // Sample point of a cycle: record an acceptance on u0.
  task automatic half();
    exp_t e;
    @(negedge clk);
    if (iv && ir) begin
      e.d = idt;
      e.t = itg;
      e.acc = cyc;
      e.lat = ic ? 1 : 2;
      q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      half();
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    fl = 0; iv = 0; ic = 0; idt = 0; itg = 0; ordy = 1;
    fl1 = 0; iv1 = 0; ic1 = 0; idt1 = 0; itg1 = 0; ordy1 = 1;
    iv = 1;
    half();
    chk("rst_ready", 64'(ir), 64'(0));
    chk("rst_ready1", 64'(ir1), 64'(0));
    chk("rst_busy1", 64'(busy1), 64'(0));
    step();
    iv = 0;
    rst_n = 1;
    idle(2);

    // single add/mul op, out after 2 cycles
    iv = 1; ic = 0; itg = 3; idt = 32'hA5A5A5A5;
    half();
    chk("t028_ready", 64'(ir), 64'(1));
    step();
    iv = 0;
    idle(4);

    // class 1 blocked behind class 0 in r[2]
    iv = 1; ic = 0; itg = 1; idt = $urandom;
    half();
    chk("t029_rdy0", 64'(ir), 64'(1));
    step();
    ic = 1; itg = 2; idt = $urandom;
    half();
    chk("t029_block", 64'(ir), 64'(0));
    step();
    half();
    chk("t029_accept", 64'(ir), 64'(1));
    step();
    iv = 0;
    idle(4);

    // back-pressure for 4 cycles
    iv = 1; ic = 0; itg = 10; idt = $urandom;
    half(); step();
    itg = 11; idt = $urandom;
    half(); step();
    ic = 1; itg = 12; idt = $urandom; ordy = 0;
    repeat (4) begin
      half();
      chk("t031_noready", 64'(ir), 64'(0));
      chk("t031_ov", 64'(ov), 64'(1));
      step();
    end
    ordy = 1;
    half();
    chk("t031_drain0", 64'(ov), 64'(1));
    step();
    half();
    chk("t031_drain1", 64'(ov), 64'(1));
    step();
    iv = 0;
    idle(4);

    // flush with two ops in flight and a pending input
    iv = 1; ic = 0; itg = 20; idt = $urandom;
    half(); step();
    itg = 21; idt = $urandom;
    half(); step();
    fl = 1; itg = 22;
    half();
    chk("flush_ov", 64'(ov), 64'(0));
    chk("flush_ready", 64'(ir), 64'(0));
    step();
    fl = 0; iv = 0;
    half();
    chk("flush_busy", 64'(busy), 64'(0));
    step();
    idle(4);

    // reset dropped while a result waits at the output
    ordy = 0;
    iv = 1; ic = 0; itg = 30; idt = $urandom;
    half(); step();
    iv = 0;
    half(); step();
    half();
    chk("rstmid_pre", 64'(ov), 64'(1));
    #2;
    rst_n = 0;
    #1;
    chk("rstmid_ov", 64'(ov), 64'(0));
    chk("rstmid_busy", 64'(busy), 64'(0));
    step();
    half();
    step();
    rst_n = 1;
    ordy = 1;
    idle(3);

    // u1: zero-latency bypass on an empty pipe
    iv1 = 1; ic1 = 1; itg1 = 7; idt1 = $urandom;
    half();
    chk("byp_ov", 64'(ov1), 64'(1));
    chk("byp_tag", 64'(otg1), 64'(7));
    chk("byp_data", 64'(odt1), 64'(idt1));
    chk("byp_busy", 64'(busy1), 64'(0));
    chk("byp_ready", 64'(ir1), 64'(1));
    step();
    iv1 = 0;
    half();
    chk("byp_after", 64'(ov1), 64'(0));
    step();

    // u1: short op overtakes a long one
    iv1 = 1; ic1 = 0; itg1 = 1; idt1 = $urandom;
    half();
    chk("ovt_rdy0", 64'(ir1), 64'(1));
    step();
    ic1 = 1; itg1 = 2; idt1 = $urandom;
    half();
    chk("ovt_c1_ov", 64'(ov1), 64'(1));
    chk("ovt_c1_tag", 64'(otg1), 64'(2));
    chk("ovt_c1_busy", 64'(busy1), 64'(1));
    step();
    iv1 = 0;
    half();
    chk("ovt_c2_ov", 64'(ov1), 64'(0));
    step();
    half();
    chk("ovt_c3_ov", 64'(ov1), 64'(1));
    chk("ovt_c3_tag", 64'(otg1), 64'(1));
    step();
    half();
    chk("ovt_c4_ov", 64'(ov1), 64'(0));
    step();

    // random traffic on u0
    for (int n = 0; n < 400; n++) begin
      iv = 1'($urandom_range(0, 1));
      ic = 1'($urandom_range(0, 1));
      idt = $urandom;
      itg = 5'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      fl = ($urandom_range(0, 49) == 0);
      half();
      step();
    end
    iv = 0; fl = 0; ordy = 1;
    idle(8);
    chk("drain_empty", 64'(q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
